neuron_mac: RTL and testbench
=============================

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 Parameter WIDTH, default 32: data word width, signed two's complement.
REQ-002 Parameter FL, default 24: fractional bits; all data ports are Q(WIDTH-FL).FL (Q8.24 at defaults).
REQ-003 Parameter N_IN, default 4, legal range 1..16: number of (x, w) pairs per neuron evaluation.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 en  input  1: global stall; when low, all state holds; same enable that drives the downstream sigmoid stage.
REQ-007 start  input  1: begin one evaluation; sampled only in IDLE.
REQ-008 bias  input  WIDTH: neuron bias; captured on the edge that accepts start.
REQ-009 in_valid  input  1: x_in/w_in carry a pair this cycle.
REQ-010 x_in  input  WIDTH: activation operand.
REQ-011 w_in  input  WIDTH: weight operand.
REQ-012 busy  output  1: high from the start-accept edge until the result edge.
REQ-013 y  output  WIDTH: saturated pre-activation sum(x*w)+bias; feeds the sigmoid input a.
REQ-014 out_valid  output  1: y is new this cycle.

Function
REQ-015 FSM states: IDLE, ACC, FIN.
- IDLE -> ACC on en & start; bias captured; accumulator and pair counter cleared.
- ACC -> FIN on the edge that accepts pair number N_IN.
- FIN -> IDLE unconditionally (when en high).
REQ-016 A pair is accepted only on a rising edge with en=1, in_valid=1 and state ACC; in_valid in IDLE or FIN is ignored.
REQ-017 Each accepted pair adds the full 2*WIDTH-bit signed product x_in*w_in to an accumulator of 2*WIDTH+4 bits (sign-extended); no intermediate overflow is possible for N_IN<=16.
REQ-018 In FIN, the accumulator is added to bias sign-extended and left-shifted by FL, then arithmetically shifted right by FL (truncation toward minus infinity, same bit-slice rule as the sigmoid stage).
REQ-019 The shifted result saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and is registered into y.
REQ-020 out_valid is a registered pulse: high for exactly one en-qualified cycle, starting on the edge that leaves FIN.
REQ-021 Latency: y/out_valid update on the first en-qualified edge after the edge accepting the last pair.
REQ-022 y holds its value between results; it changes only on the out_valid edge.
REQ-023 start during ACC or FIN is ignored; start in the cycle out_valid is high is accepted (back-to-back operation).
REQ-024 Gaps in in_valid during ACC are allowed and unbounded; no timeout.
REQ-025 en=0: state, counter, accumulator, bias, y, out_valid and busy all hold; an out_valid pulse stretches for as long as en stays low.

Reset
REQ-026 rst=1 on a rising edge: state IDLE, accumulator/counter/bias cleared, y=0, out_valid=0, busy=0; rst overrides en and start.
REQ-027 Reset mid-evaluation discards the partial sum; no out_valid follows; the next start begins a clean evaluation.

Verification
REQ-028 Basic: N_IN=4, bias=0, four pairs x=0x01000000, w=0x00800000 -> y=0x02000000, out_valid one cycle, one edge after the 4th pair.
REQ-029 Bias/sign: pairs x=0x01000000, w=0xFF000000 (x4), bias=0x00800000 -> y=0xFC800000 (-3.5).
REQ-030 Truncation: one pair x=0xFFFFFFFF, w=0x00000001, rest zero, bias=0 -> y=0xFFFFFFFF; with x=0x00000001 instead -> y=0x00000000.
REQ-031 Saturation: four pairs x=w=0x7F000000 -> y=0x7FFFFFFF; x=0x7F000000, w=0x81000000 -> y=0x80000000.
REQ-032 Stall/gaps: REQ-028 stimulus with in_valid gaps and en low for 3 cycles mid-ACC and in FIN -> same y; out_valid stretched exactly while en low; pairs presented while en low not counted.
REQ-033 Reset: rst after 2 of 4 pairs -> out_valid never rises; a following REQ-028 run -> y=0x02000000; start while busy -> no effect.

Source files
------------

// File: rtl/neuron_mac_if.sv
// Handshake bundle between a neuron evaluation source and the MAC front end.
// The master side drives the operands and the slave side returns the result.
interface neuron_mac_if #(
    parameter int WIDTH = 32
);
    logic                    start;
    logic signed [WIDTH-1:0] bias;
    logic                    in_valid;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] w_in;
    logic                    busy;
    logic signed [WIDTH-1:0] y;
    logic                    out_valid;

    modport master (
        output start, bias, in_valid, x_in, w_in,
        input  busy, y, out_valid
    );

    modport slave (
        input  start, bias, in_valid, x_in, w_in,
        output busy, y, out_valid
    );
endinterface

// File: rtl/neuron_mac.sv
// Fixed-point neuron pre-activation: y = sat(sum(x*w) + bias), evaluated over
// N_IN operand pairs with a global stall shared with the downstream sigmoid.
module neuron_mac #(
    parameter int WIDTH = 32,
    parameter int FL    = 24,
    parameter int N_IN  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    neuron_mac_if.slave  io
);
    localparam int PROD_W = 2 * WIDTH;
    localparam int ACC_W  = 2 * WIDTH + 4;
    localparam int CNT_W  = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] bias_q, bias_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  fin_sum;

    // Clamp the re-scaled sum into the signed output word range.
    function automatic logic signed [WIDTH-1:0] sat_y(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI) begin
            sat_y = SAT_HI[WIDTH-1:0];
        end else if (v < SAT_LO) begin
            sat_y = SAT_LO[WIDTH-1:0];
        end else begin
            sat_y = v[WIDTH-1:0];
        end
    endfunction

    assign prod    = PROD_W'(io.x_in) * PROD_W'(io.w_in);
    assign fin_sum = acc_q + (ACC_W'(bias_q) <<< FL);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        bias_d      = bias_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        // With en low nothing moves, which is what stretches an out_valid pulse.
        if (en) begin
            out_valid_d = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (io.start) begin
                        state_d = S_ACC;
                        bias_d  = io.bias;
                        acc_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                S_ACC: begin
                    if (io.in_valid) begin
                        acc_d = acc_q + ACC_W'(prod);
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    // Arithmetic shift truncates toward minus infinity.
                    y_d         = sat_y(fin_sum >>> FL);
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            bias_q      <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign io.busy      = busy_q;
    assign io.y         = y_q;
    assign io.out_valid = out_valid_q;
endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: expected results are queued when an
// evaluation is launched and compared when the DUT reports a result.
module tb_neuron_mac;
    logic clk = 1'b0;
    logic rst;
    logic en;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    neuron_mac_if #(.WIDTH(32)) io ();

    neuron_mac #(.WIDTH(32), .FL(24), .N_IN(4)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .io  (io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [31:0] b,
                                          input logic [31:0] xa[4],
                                          input logic [31:0] wa[4]);
        logic signed [67:0] s;
        logic signed [67:0] bb;
        longint p;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            p = longint'($signed(xa[i])) * longint'($signed(wa[i]));
            s = s + 68'(p);
        end
        bb = $signed(b);
        s  = s + (bb <<< 24);
        s  = s >>> 24;
        if (s > 68'sh0_7FFF_FFFF) return 32'h7FFF_FFFF;
        if (s < -68'sh0_8000_0000) return 32'h8000_0000;
        return s[31:0];
    endfunction

    // A result is consumed on the cycle where out_valid is high and en lets it go.
    always @(negedge clk) begin
        if (!rst && io.out_valid && en) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 64'd1, 64'd0);
            end else begin
                chk("y", {32'd0, io.y}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic eval(input logic [31:0] b, input logic [31:0] xa[4],
                        input logic [31:0] wa[4], input logic [31:0] expv,
                        input bit gaps, input bit start_mid);
        exp_q.push_back(expv);
        io.start = 1'b1;
        io.bias  = b;
        tick();
        io.start = 1'b0;
        chk("busy_after_start", {63'd0, io.busy}, 64'd1);
        chk("ov_single_cycle", {63'd0, io.out_valid}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                io.in_valid = 1'b0;
                io.x_in     = $urandom;
                io.w_in     = $urandom;
                repeat ($urandom_range(1, 3)) tick();
            end
            io.in_valid = 1'b1;
            io.x_in     = xa[i];
            io.w_in     = wa[i];
            if (start_mid) begin
                io.start = 1'b1;
                io.bias  = 32'h7F00_0000;
            end
            tick();
        end
        io.in_valid = 1'b0;
        io.start    = 1'b0;
        chk("latency_not_early", {63'd0, io.out_valid}, 64'd0);
        tick();
        chk("ov_on_time", {63'd0, io.out_valid}, 64'd1);
        chk("busy_cleared", {63'd0, io.busy}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] xa[4];
        logic [31:0] wa[4];
        logic [31:0] b;

        rst = 1'b1; en = 1'b1;
        io.start = 1'b0; io.bias = '0; io.in_valid = 1'b0; io.x_in = '0; io.w_in = '0;
        repeat (2) tick();
        chk("rst_y", {32'd0, io.y}, 64'd0);
        chk("rst_out_valid", {63'd0, io.out_valid}, 64'd0);
        chk("rst_busy", {63'd0, io.busy}, 64'd0);
        rst = 1'b0;
        tick();

        // Basic, bias/sign, truncation, saturation.
        eval(32'h0, '{4{32'h0100_0000}}, '{4{32'h0080_0000}}, 32'h0200_0000, 1'b0, 1'b0);
        eval(32'h0080_0000, '{4{32'h0100_0000}}, '{4{32'hFF00_0000}}, 32'hFC80_0000, 1'b0, 1'b0);
        eval(32'h0, '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0}, '{32'h1, 32'h0, 32'h0, 32'h0},
             32'hFFFF_FFFF, 1'b0, 1'b0);
        eval(32'h0, '{32'h1, 32'h0, 32'h0, 32'h0}, '{32'h1, 32'h0, 32'h0, 32'h0},
             32'h0000_0000, 1'b0, 1'b0);
        eval(32'h0, '{4{32'h7F00_0000}}, '{4{32'h7F00_0000}}, 32'h7FFF_FFFF, 1'b0, 1'b0);
        eval(32'h0, '{4{32'h7F00_0000}}, '{4{32'h8100_0000}}, 32'h8000_0000, 1'b0, 1'b0);
        tick();

        // Stall mid-ACC with junk pairs presented, stall in FIN, stretched out_valid.
        exp_q.push_back(32'h0200_0000);
        io.start = 1'b1; io.bias = 32'h0;
        tick();
        io.start = 1'b0;
        io.in_valid = 1'b1; io.x_in = 32'h0100_0000; io.w_in = 32'h0080_0000;
        repeat (2) tick();
        en = 1'b0; io.x_in = 32'h7F00_0000; io.w_in = 32'h7F00_0000;
        repeat (3) tick();
        chk("stall_busy_hold", {63'd0, io.busy}, 64'd1);
        en = 1'b1; io.in_valid = 1'b0;
        repeat (2) tick();
        io.in_valid = 1'b1; io.x_in = 32'h0100_0000; io.w_in = 32'h0080_0000;
        repeat (2) tick();
        io.in_valid = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fin_stall_no_ov", {63'd0, io.out_valid}, 64'd0);
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ov_stretched", {63'd0, io.out_valid}, 64'd1);
            chk("y_stretched", {32'd0, io.y}, 64'h0200_0000);
            tick();
        end
        en = 1'b1;
        tick();
        chk("ov_drops_after_stretch", {63'd0, io.out_valid}, 64'd0);

        // Reset mid-evaluation discards the partial sum.
        io.start = 1'b1; io.bias = 32'h0100_0000;
        tick();
        io.start = 1'b0;
        io.in_valid = 1'b1; io.x_in = 32'h0100_0000; io.w_in = 32'h0100_0000;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {63'd0, io.busy}, 64'd0);
        chk("midrst_y", {32'd0, io.y}, 64'd0);
        repeat (4) begin
            tick();
            chk("midrst_no_ov", {63'd0, io.out_valid}, 64'd0);
        end
        io.in_valid = 1'b0;
        // Clean run afterwards, with start/bias wiggled during ACC.
        eval(32'h0, '{4{32'h0100_0000}}, '{4{32'h0080_0000}}, 32'h0200_0000, 1'b0, 1'b1);

        // Randomised runs with gaps, back-to-back.
        for (int k = 0; k < 6; k++) begin
            b = $urandom;
            for (int i = 0; i < 4; i++) begin
                xa[i] = (k < 3) ? 32'($signed(16'($urandom))) <<< 8 : $urandom;
                wa[i] = (k < 3) ? 32'($signed(16'($urandom))) <<< 8 : $urandom;
            end
            eval(b, xa, wa, model(b, xa, wa), 1'b1, 1'b0);
        end
        repeat (3) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
